// File: rtl/jk_seq_driver.sv
// ---------------------------------------------------------------------------
// jk_seq_driver
//   Sequence driver/checker for a synchronous-clear JK flip-flop. Target q bits
//   arrive over a valid/ready handshake into a FIFO. Each bit is popped, its
//   J/K excitation is derived from the currently observed q, driven for one
//   cycle, and the flip-flop's response is checked on the following cycle.
//
// Configuration macro: JK_TOGGLE_PREF_EN
//   defined   : every state change is excited with J=K=1 (toggle form)
//   undefined : set/reset form, (q,t) 01->10, 10->01, no-change -> 00
//
// Ports
//   clk        clock, rising edge
//   clr        synchronous active-high reset
//   in_valid   target bit offered
//   in_bit     target q value
//   in_ready   FIFO can accept (not full, from registered count)
//   q_fb       q returned from the driven flip-flop
//   j, k       registered excitation, non-zero only in DRIVE
//   chk_valid  check performed this cycle
//   err_pulse  q_fb differed from the expected bit during the check
//   err_cnt    saturating mismatch count
//   busy       FIFO non-empty or FSM not idle
// ---------------------------------------------------------------------------
module jk_seq_driver #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    input  logic             q_fb,
    output logic             j,
    output logic             k,
    output logic             chk_valid,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [1:0]       state;
    logic             exp_bit;

    logic fifo_empty;
    logic push;
    logic pop;
    logic head;
    logic j_nxt;
    logic k_nxt;

    assign fifo_empty = (count == '0);
    // Readiness comes from the registered count only, so a full FIFO refuses
    // a push even when a pop happens in the same cycle.
    assign in_ready   = (count != FULL_CNT);
    assign push       = in_valid && in_ready;
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign head       = mem[rd_ptr];

    // Excitation for moving q_fb to the target head bit.
    always_comb begin
        j_nxt = 1'b0;
        k_nxt = 1'b0;
`ifdef JK_TOGGLE_PREF_EN
        j_nxt = q_fb ^ head;
        k_nxt = q_fb ^ head;
`else
        j_nxt = head & ~q_fb;
        k_nxt = ~head & q_fb;
`endif
    end

    // FIFO storage; contents need no reset since pointers/count are flushed.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_bit;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // IDLE pops and registers j/k so they appear exactly in the DRIVE cycle;
    // every other path zeroes them, so the flip-flop holds outside DRIVE.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= S_IDLE;
            exp_bit <= 1'b0;
            j       <= 1'b0;
            k       <= 1'b0;
            err_cnt <= '0;
        end else begin
            j <= 1'b0;
            k <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        exp_bit <= head;
                        j       <= j_nxt;
                        k       <= k_nxt;
                        state   <= S_DRIVE;
                    end
                end
                S_DRIVE: state <= S_CHECK;
                S_CHECK: begin
                    if (err_pulse && err_cnt != ERR_MAX)
                        err_cnt <= err_cnt + 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A clr landing on the CHECK cycle aborts that bit, so no check is reported.
    assign chk_valid = (state == S_CHECK) && !clr;
    assign err_pulse = chk_valid && (q_fb != exp_bit);
    assign busy      = !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_jk_seq_driver.sv
module tb_jk_seq_driver;

    localparam int DEPTH   = 8;
    localparam int ERR_W   = 8;
    localparam int ERR_MAX = 255;

    logic             clk = 1'b0;
    logic             clr;
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             q_fb;
    logic             j;
    logic             k;
    logic             chk_valid;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic             busy;

    jk_seq_driver #(.DEPTH(DEPTH), .AW(3), .ERR_W(ERR_W)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .q_fb(q_fb), .j(j), .k(k),
        .chk_valid(chk_valid), .err_pulse(err_pulse), .err_cnt(err_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Ideal JK flip-flop under drive, optionally replaced by a stuck-at-0 q.
    logic q_ff = 1'b0;
    logic stuck = 1'b0;
    assign q_fb = stuck ? 1'b0 : q_ff;

    always @(posedge clk) begin
        if (clr) q_ff <= 1'b0;
        else case ({j, k})
            2'b10:   q_ff <= 1'b1;
            2'b01:   q_ff <= 1'b0;
            2'b11:   q_ff <= ~q_ff;
            default: q_ff <= q_ff;
        endcase
    end

    int passed = 0;
    int total  = 0;

    // Reference: a queue of accepted targets plus a phase counter
    // (0 waiting, 1 excitation cycle, 2 check cycle).
    bit   mq[$];
    int   ph = 0;
    bit   mexp = 0;
    bit   mq_at_pop = 0;
    int   merr = 0;
    bit   mon_en = 0;
    int   nchk = 0;
    int   nerrp = 0;
    int   npop = 0;
    bit   saw_full = 0;
    logic [1:0] jkq[$];

    function automatic logic [1:0] exc(input logic q, input logic t);
        logic [1:0] r;
        case ({q, t})
`ifdef JK_TOGGLE_PREF_EN
            2'b01:   r = 2'b11;
            2'b10:   r = 2'b11;
`else
            2'b01:   r = 2'b10;
            2'b10:   r = 2'b01;
`endif
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            logic [5:0] e;
            logic [5:0] a;
            logic [1:0] ejk;
            bit rdy;
            ejk = (ph == 1) ? exc(mq_at_pop, mexp) : 2'b00;
            rdy = (mq.size() < DEPTH);
            e = {ejk, (ph == 2) && !clr, (ph == 2) && !clr && (q_fb !== mexp),
                 rdy, (mq.size() > 0) || (ph != 0)};
            a = {j, k, chk_valid, err_pulse, in_ready, busy};
            total++;
            if (a !== e) $display("FAIL cycle_outputs t=%0t {j,k,chk,err,rdy,busy} got %b exp %b", $time, a, e);
            else passed++;
            total++;
            if (err_cnt !== ERR_W'(merr)) $display("FAIL cycle_err_cnt t=%0t got %0d exp %0d", $time, err_cnt, merr);
            else passed++;
            if (chk_valid === 1'b1) nchk++;
            if (err_pulse === 1'b1) nerrp++;
            if (in_ready === 1'b0) saw_full = 1;
            if (ph == 1) jkq.push_back({j, k});
            // advance reference to the next cycle
            if (clr) begin
                mq.delete(); ph = 0; merr = 0; mexp = 0;
            end else begin
                if (ph == 2) begin
                    if (q_fb !== mexp) merr = (merr < ERR_MAX) ? merr + 1 : ERR_MAX;
                    ph = 0;
                end else if (ph == 1) begin
                    ph = 2;
                end else if (mq.size() > 0) begin
                    mexp = mq.pop_front();
                    mq_at_pop = q_fb;
                    ph = 1;
                    npop++;
                end
                if (in_valid && rdy) mq.push_back(in_bit);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_clr();
        clr = 1'b1; in_valid = 1'b0;
        tick(); tick();
        clr = 1'b0;
    endtask

    task automatic push_bit(input logic b);
        bit acc = 0;
        in_valid = 1'b1; in_bit = b;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            tick();
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            $display("FAIL push_timeout bit=%b never accepted within 50 cycles", b);
        end
    endtask

    task automatic drain(input int budget);
        bit done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            done = (busy === 1'b0);
            if (!done) tick();
        end
        if (!done) begin
            total++;
            $display("FAIL drain_timeout busy still %b after %0d cycles", busy, budget);
        end
        tick();
    endtask

    task automatic test_reset();
        clr = 1'b1; in_valid = 1'b0; in_bit = 1'b0; stuck = 1'b0;
        tick(); tick();
        clr = 1'b0;
        @(negedge clk);
        total++; if ({j, k} !== 2'b00) $display("FAIL reset_jk got %b exp 00", {j, k}); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
        total++; if (err_cnt !== '0) $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); else passed++;
        total++; if (chk_valid !== 1'b0) $display("FAIL reset_chk_valid got %b exp 0", chk_valid); else passed++;
        mon_en = 1;
        tick();
    endtask

    task automatic test_ideal_seq();
        int c0;
        logic [1:0] expv[4] = '{2'b10, 2'b00, 2'b01, 2'b00};
        do_clr(); stuck = 1'b0; jkq.delete(); c0 = nchk;
        push_bit(1'b1); push_bit(1'b1); push_bit(1'b0); push_bit(1'b0);
        drain(60);
        total++; if (jkq.size() != 4) $display("FAIL ideal_drive_count got %0d exp 4", jkq.size()); else passed++;
        for (int i = 0; i < 4 && i < jkq.size(); i++) begin
            total++;
            if (jkq[i] !== expv[i]) $display("FAIL ideal_jk[%0d] got %b exp %b", i, jkq[i], expv[i]); else passed++;
        end
        total++; if (nchk - c0 != 4) $display("FAIL ideal_chk_pulses got %0d exp 4", nchk - c0); else passed++;
        total++; if (err_cnt !== '0) $display("FAIL ideal_err_cnt got %0d exp 0", err_cnt); else passed++;
    endtask

    task automatic test_stuck_low();
        int e0;
        do_clr(); stuck = 1'b1; e0 = nerrp;
        push_bit(1'b1); push_bit(1'b0); push_bit(1'b1);
        drain(60);
        total++; if (err_cnt !== 8'd2) $display("FAIL stuck_err_cnt got %0d exp 2", err_cnt); else passed++;
        total++; if (nerrp - e0 != 2) $display("FAIL stuck_err_pulses got %0d exp 2", nerrp - e0); else passed++;
        stuck = 1'b0;
    endtask

    task automatic test_back_to_back();
        int c0;
        do_clr(); stuck = 1'b0; saw_full = 0; c0 = nchk;
        for (int i = 0; i < 24; i++) push_bit(1'($urandom_range(0, 1)));
        drain(200);
        total++; if (!saw_full) $display("FAIL b2b_full in_ready never dropped, got 1 exp 0"); else passed++;
        total++; if (nchk - c0 != 24) $display("FAIL b2b_chk_pulses got %0d exp 24", nchk - c0); else passed++;
        total++; if (err_cnt !== '0) $display("FAIL b2b_err_cnt got %0d exp 0", err_cnt); else passed++;
    endtask

    task automatic test_clr_abort();
        int c0, p0;
        bit hit = 0;
        do_clr(); stuck = 1'b0; c0 = nchk; p0 = npop;
        push_bit(1'b1); push_bit(1'b0); push_bit(1'b1); push_bit(1'b0);
        for (int n = 0; n < 40 && !hit; n++) begin
            if (ph == 1 && npop - p0 == 2) hit = 1;
            else tick();
        end
        total++;
        if (!hit) $display("FAIL abort_reach_drive never reached DRIVE of bit 2, got 0 exp 1");
        else passed++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        total++; if ({j, k} !== 2'b00) $display("FAIL abort_jk got %b exp 00", {j, k}); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready got %b exp 1", in_ready); else passed++;
        total++; if (err_cnt !== '0) $display("FAIL abort_err_cnt got %0d exp 0", err_cnt); else passed++;
        tick(); tick(); tick(); tick();
        total++; if (nchk - c0 != 1) $display("FAIL abort_chk_pulses got %0d exp 1", nchk - c0); else passed++;
    endtask

    task automatic test_excitation_mode();
        logic [1:0] e0, e1;
`ifdef JK_TOGGLE_PREF_EN
        e0 = 2'b11; e1 = 2'b11;
`else
        e0 = 2'b10; e1 = 2'b01;
`endif
        do_clr(); stuck = 1'b0; jkq.delete();
        push_bit(1'b1); push_bit(1'b0);
        drain(40);
        total++; if (jkq.size() != 2) $display("FAIL mode_drive_count got %0d exp 2", jkq.size()); else passed++;
        total++; if (jkq.size() > 0 && jkq[0] !== e0) $display("FAIL mode_jk0 got %b exp %b", jkq[0], e0); else passed++;
        total++; if (jkq.size() > 1 && jkq[1] !== e1) $display("FAIL mode_jk1 got %b exp %b", jkq[1], e1); else passed++;
        total++; if (err_cnt !== '0) $display("FAIL mode_err_cnt got %0d exp 0", err_cnt); else passed++;
    endtask

    task automatic test_random();
        do_clr();
        for (int n = 0; n < 400; n++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            in_bit   = 1'($urandom_range(0, 1));
            if (n % 50 == 0) stuck = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0; stuck = 1'b0;
        drain(100);
    endtask

    task automatic test_saturate();
        do_clr(); stuck = 1'b1;
        for (int i = 0; i < 300; i++) push_bit(1'b1);
        drain(100);
        total++; if (err_cnt !== 8'd255) $display("FAIL sat_err_cnt got %0d exp 255", err_cnt); else passed++;
        stuck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ideal_seq();
        test_stuck_low();
        test_back_to_back();
        test_clr_abort();
        test_excitation_mode();
        test_random();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
